avs_event_capture_ctrl: RTL and testbench

Controller that sequences capture of one acoustic event window around the detector's eventDetected strobe. It keeps a pre-trigger ring of recent stream samples and captures a fixed post-trigger window. It then reads the whole window out to a downstream consumer over a valid/ready handshake, and enforces a holdoff before re-arming. It sits between the sample stream and event detector in topLevel and the readout/host path.

---
 rtl/avs_event_capture_ctrl.sv | 136 +++++++++++++
 tb/tb_avs_event_capture_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/avs_event_capture_ctrl.sv
// avs_event_capture_ctrl: captures a pre/post-trigger sample window around eventDetected and reads it out over valid/ready.
// Define AVS_TRIG_TIMESTAMP_EN to add trig_time, the valid-sample count latched on the trigger sample.
module avs_event_capture_ctrl #(
    parameter int DATA_W   = 16,
    parameter int PRE_LEN  = 8,
    parameter int POST_LEN = 24,
    parameter int HOLDOFF  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              continuous,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] stream,
    input  logic              eventDetected,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              armed,
`ifdef AVS_TRIG_TIMESTAMP_EN
    output logic [31:0]       trig_time,
`endif
    output logic              overrun
);
    localparam int PW = PRE_LEN > 1 ? $clog2(PRE_LEN) : 1;
    localparam int QW = POST_LEN > 1 ? $clog2(POST_LEN) : 1;
    localparam logic [7:0] C_PRE       = 8'(PRE_LEN);
    localparam logic [7:0] C_PRE_LAST  = 8'(PRE_LEN - 1);
    localparam logic [7:0] C_POST_LAST = 8'(POST_LEN - 1);
    localparam logic [7:0] C_TOT_LAST  = 8'(PRE_LEN + POST_LEN - 1);
    localparam logic [7:0] C_HO_LAST   = 8'(HOLDOFF - 1);
    localparam logic [PW-1:0] C_PTR_LAST = PW'(PRE_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_ARMED, S_POST, S_READOUT, S_HOLDOFF} state_t;

    state_t r_state, w_state_nx, w_rearm;
    logic [DATA_W-1:0] r_ring [PRE_LEN];
    logic [DATA_W-1:0] r_post [POST_LEN];
    logic [PW-1:0] r_wr_ptr, w_ring_rd;
    logic [QW-1:0] w_post_rd;
    logic [7:0] r_cnt, w_ring_sum;
    logic [DATA_W-1:0] r_rd_data, w_word;
    logic r_rd_valid, r_rd_last, r_busy, r_armed, r_overrun;
    logic w_ev, w_trig, w_xfer, w_load, w_ring_we, w_post_we, w_cnt_inc;

    assign w_ev      = sample_valid && eventDetected;
    assign w_trig    = r_state == S_ARMED && w_ev;
    assign w_xfer    = r_rd_valid && rd_ready;
    assign w_load    = r_state == S_READOUT && (!r_rd_valid || (w_xfer && !r_rd_last));
    assign w_ring_we = sample_valid && (r_state == S_PREFILL || (r_state == S_ARMED && !eventDetected));
    assign w_post_we = w_trig || (sample_valid && r_state == S_POST);
    assign w_cnt_inc = w_load || (sample_valid && (r_state == S_PREFILL || r_state == S_POST || r_state == S_HOLDOFF));
    assign w_rearm   = continuous ? S_PREFILL : S_IDLE;

    // During readout r_cnt is the index of the next word to fetch; ring words start at the oldest entry.
    assign w_ring_sum = 8'(r_wr_ptr) + r_cnt;
    assign w_ring_rd  = PW'(w_ring_sum >= C_PRE ? w_ring_sum - C_PRE : w_ring_sum);
    assign w_post_rd  = QW'(r_cnt - C_PRE);
    assign w_word     = r_cnt < C_PRE ? r_ring[w_ring_rd] : r_post[w_post_rd];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:    w_state_nx = arm ? S_PREFILL : S_IDLE;
            S_PREFILL: if (sample_valid && r_cnt == C_PRE_LAST) w_state_nx = S_ARMED;
            S_ARMED:   if (w_trig) w_state_nx = POST_LEN == 1 ? S_READOUT : S_POST;
            S_POST:    if (sample_valid && r_cnt == C_POST_LAST) w_state_nx = S_READOUT;
            S_READOUT: if (w_xfer && r_rd_last) w_state_nx = HOLDOFF == 0 ? w_rearm : S_HOLDOFF;
            S_HOLDOFF: if (sample_valid && r_cnt == C_HO_LAST) w_state_nx = w_rearm;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_armed    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_busy    <= w_state_nx != S_IDLE;
            r_armed   <= w_state_nx == S_ARMED;
            r_wr_ptr  <= (w_state_nx == S_PREFILL && r_state != S_PREFILL) ? '0 :
                         w_ring_we ? (r_wr_ptr == C_PTR_LAST ? '0 : r_wr_ptr + 1'b1) : r_wr_ptr;
            r_cnt     <= w_state_nx != r_state ? (w_state_nx == S_POST ? 8'd1 : 8'd0) :
                         w_cnt_inc ? r_cnt + 8'd1 : r_cnt;
            r_overrun <= (r_state == S_IDLE && arm) ? 1'b0 :
                         (w_ev && (r_state == S_POST || r_state == S_READOUT || r_state == S_HOLDOFF)) ? 1'b1 : r_overrun;
            if (w_load) begin
                r_rd_data  <= w_word;
                r_rd_last  <= r_cnt == C_TOT_LAST;
                r_rd_valid <= 1'b1;
            end else if (w_xfer && r_rd_last) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
        end
    end

    // Sample storage carries no reset; contents are only read after being written.
    always_ff @(posedge clock) begin
        if (w_ring_we) r_ring[r_wr_ptr] <= stream;
        if (w_post_we) r_post[w_trig ? '0 : r_cnt[QW-1:0]] <= stream;
    end

`ifdef AVS_TRIG_TIMESTAMP_EN
    logic [31:0] r_ts, r_trig_time;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts        <= '0;
            r_trig_time <= '0;
        end else begin
            r_ts <= r_ts + 32'(sample_valid);
            if (w_trig) r_trig_time <= r_ts;
        end
    end

    assign trig_time = r_trig_time;
`endif

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign busy     = r_busy;
    assign armed    = r_armed;
    assign overrun  = r_overrun;
endmodule

// File: tb/tb_avs_event_capture_ctrl.sv
// tb_avs_event_capture_ctrl: scenario table, hand-written corner sequences and a randomized
// run against a queue-based window model for avs_event_capture_ctrl.
module tb_avs_event_capture_ctrl;
    localparam int DW = 16, PRE = 4, POST = 4, HO = 8;

    logic clock = 1'b0, reset = 1'b1, arm = 1'b0, continuous = 1'b0;
    logic sample_valid = 1'b0, eventDetected = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] stream = '0;
    logic rd_valid, rd_last, busy, armed, overrun;
    logic [DW-1:0] rd_data;
`ifdef AVS_TRIG_TIMESTAMP_EN
    logic [31:0] trig_time;
`endif

    int n_tests = 0, n_fail = 0, n = 0;

    typedef struct {
        int ev1;
        int ev2;
        int stall_word;
        int stall_n;
        int ev_ro;
        int first;
        int ovr;
    } vec_t;
    vec_t vecs[6];
    vec_t v2;

    always #5 clock = ~clock;

    avs_event_capture_ctrl #(.DATA_W(DW), .PRE_LEN(PRE), .POST_LEN(POST), .HOLDOFF(HO)) dut (
        .clock(clock), .reset(reset), .arm(arm), .continuous(continuous),
        .sample_valid(sample_valid), .stream(stream), .eventDetected(eventDetected),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .armed(armed),
`ifdef AVS_TRIG_TIMESTAMP_EN
        .trig_time(trig_time),
`endif
        .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Feeds sample n+1 this cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        stream = DW'(n + 1);
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_armed"}, armed, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic do_arm(input bit cont);
        continuous = cont;
        sample_valid = 1'b1;
        eventDetected = 1'b0;
        rd_ready = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        n = 0;
        chk("arm_clears_ovr", overrun, 0);
        chk("arm_busy", busy, 1);
        chk("arm_not_armed", armed, 0);
    endtask

    task automatic feed_window(input vec_t v);
        logic [DW-1:0] words[$];
        int stalled = 0;
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            eventDetected = (n + 1 == v.ev1) || (n + 1 == v.ev2) || (v.ev_ro != 0 && rd_valid && words.size() == 0);
            rd_ready = !(rd_valid && int'(rd_data) == v.stall_word && stalled < v.stall_n);
            if (rd_valid && rd_ready) begin
                words.push_back(rd_data);
                chk("rd_last", rd_last, words.size() == 8 ? 1 : 0);
                done = rd_last;
            end
            step();
            if (!rd_ready) begin
                stalled++;
                chk("stall_valid", rd_valid, 1);
                chk("stall_data", rd_data, v.stall_word);
            end
        end
        eventDetected = 1'b0;
        rd_ready = 1'b1;
        chk("rd_valid_drop", rd_valid, 0);
        chk("window_len", words.size(), 8);
        for (int i = 0; i < words.size() && i < 8; i++) chk("window_word", words[i], v.first + i);
        chk("overrun_after_readout", overrun, v.ovr);
    endtask

    task automatic holdoff(input int cont, input int ovr);
        repeat (HO - 1) step();
        chk("holdoff_busy", busy, 1);
        step();
        chk("holdoff_exit_busy", busy, cont);
        chk("holdoff_exit_armed", armed, 0);
        chk("overrun_kept", overrun, ovr);
    endtask

    task automatic rand_run(input int cycles);
        int ph = 0, ho = 0;
        bit m_rdv = 1'b0, m_ovr = 1'b0;
        logic [DW-1:0] hist[$], win[$];
        for (int c = 0; c < cycles; c++) begin
            arm = $urandom_range(0, 15) == 0;
            if (c % 700 == 0) continuous = $urandom_range(0, 1) == 1;
            sample_valid = $urandom_range(0, 3) != 0;
            eventDetected = $urandom_range(0, 9) == 0;
            rd_ready = $urandom_range(0, 2) != 0;
            stream = DW'($urandom);
            // phases: 0 idle, 1 prefill, 2 armed, 3 post, 4 readout, 5 holdoff
            if (sample_valid && eventDetected && ph >= 3) m_ovr = 1'b1;
            case (ph)
                0: if (arm) begin ph = 1; hist.delete(); m_ovr = 1'b0; end
                1: if (sample_valid) begin
                    hist.push_back(stream);
                    if (hist.size() == PRE) ph = 2;
                end
                2: if (sample_valid) begin
                    if (eventDetected) begin
                        win = hist;
                        win.push_back(stream);
                        ph = 3;
                    end else begin
                        hist.push_back(stream);
                        void'(hist.pop_front());
                    end
                end
                3: if (sample_valid) begin
                    win.push_back(stream);
                    if (win.size() == PRE + POST) ph = 4;
                end
                4: if (!m_rdv) m_rdv = 1'b1;
                   else if (rd_ready) begin
                    void'(win.pop_front());
                    if (win.size() == 0) begin m_rdv = 1'b0; ph = 5; ho = 0; end
                end
                default: if (sample_valid) begin
                    ho++;
                    if (ho == HO) begin ph = continuous ? 1 : 0; hist.delete(); end
                end
            endcase
            @(posedge clock);
            #1;
            chk("rand_busy", busy, ph != 0 ? 1 : 0);
            chk("rand_armed", armed, ph == 2 ? 1 : 0);
            chk("rand_overrun", overrun, m_ovr);
            chk("rand_rd_valid", rd_valid, m_rdv);
            if (m_rdv) begin
                chk("rand_rd_data", rd_data, win[0]);
                chk("rand_rd_last", rd_last, win.size() == 1 ? 1 : 0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{7, 0, 0, 0, 0, 3, 0};
        vecs[1] = '{2, 9, 0, 0, 0, 5, 0};
        vecs[2] = '{7, 0, 5, 3, 0, 3, 0};
        vecs[3] = '{7, 0, 0, 0, 1, 3, 1};
        vecs[4] = '{4, 5, 0, 0, 0, 1, 0};
        vecs[5] = '{6, 8, 0, 0, 0, 2, 1};
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_arm(1'b0);
            feed_window(vecs[i]);
            holdoff(0, vecs[i].ovr);
        end
        // continuous re-arm, then a second window from the refilled ring
        do_arm(1'b1);
        feed_window(vecs[0]);
        holdoff(1, 0);
        repeat (PRE - 1) step();
        chk("cont_prefill", armed, 0);
        step();
        chk("cont_armed", armed, 1);
        continuous = 1'b0;
        v2 = '{n + 3, 0, 0, 0, 0, n - 1, 0};
        feed_window(v2);
        holdoff(0, 0);
        // asynchronous reset in the middle of POST
        do_arm(1'b0);
        for (int i = 0; i < 8; i++) begin
            eventDetected = (n + 1 == 7) || (n + 1 == 8);
            step();
        end
        eventDetected = 1'b0;
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_ovr", overrun, 1);
        #2 reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        do_arm(1'b0);
        feed_window(vecs[0]);
        holdoff(0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        rand_run(4000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
